// File: rtl/ser_deframer.sv
// ser_deframer: serial-to-word deframer on the bit clock fast_clk.
// Hunts for the SYNC_IN framing strobe, verifies LOCK_COUNT correctly placed
// syncs, then delivers 8-bit words (LSB received first) with a one-cycle
// word_valid strobe.
// Optional feature macro: DEFRAMER_ERR_CNT_EN builds the saturating sync
// error counter; without it err_count is tied to zero.
//
// Handshake: word_valid is a one-cycle strobe with no back-pressure. The
// consumer takes sample_word in the cycle word_valid is high; sample_word then
// holds until the next strobe.
module ser_deframer #(
    parameter int SYNC_PERIOD = 1,
    parameter int LOCK_COUNT  = 4
) (
    input  logic        fast_clk,
    input  logic        rst_n,
    input  logic        DATA_IN,
    input  logic        SYNC_IN,
    output logic [7:0]  sample_word,
    output logic        word_valid,
    output logic        locked,
    output logic        sync_err,
    output logic [15:0] err_count,
    output logic [1:0]  state_dbg_o
);

    localparam int WCNT_W = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(SYNC_PERIOD - 1);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_COUNT);
    localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    // Bits 0..6 of the word in flight; bit 7 is taken straight from DATA_IN.
    logic [6:0]        shift_q, shift_d;
    logic [7:0]        sample_word_q;
    logic              word_valid_q;
    logic              sync_err_q;
    logic              err_d;
    logic              deliver;

    logic              boundary;
    logic              sync_exp;
    logic              last_bit;

    assign boundary = (bit_cnt_q == 3'd0);
    assign sync_exp = boundary && (word_cnt_q == '0);
    assign last_bit = (bit_cnt_q == 3'd7);

    // Next-state, counter and framing-error decode for the alignment FSM.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q + 3'd1;
        word_cnt_d = word_cnt_q;
        good_cnt_d = good_cnt_q;
        shift_d    = shift_q;
        err_d      = 1'b0;
        deliver    = 1'b0;

        if (last_bit) begin
            word_cnt_d = (word_cnt_q == WCNT_MAX) ? '0 : word_cnt_q + 1'b1;
        end
        if (!last_bit) begin
            shift_d[bit_cnt_q] = DATA_IN;
        end

        case (state_q)
            ST_HUNT: begin
                // Counters idle at zero until a sync shows up; that bit is bit 0.
                bit_cnt_d  = 3'd0;
                word_cnt_d = '0;
                good_cnt_d = '0;
                if (SYNC_IN) begin
                    state_d    = ST_VERIFY;
                    bit_cnt_d  = 3'd1;
                    good_cnt_d = GOOD_ONE;
                end
            end

            ST_VERIFY: begin
                if (sync_exp) begin
                    if (SYNC_IN) begin
                        good_cnt_d = good_cnt_q + GOOD_ONE;
                        if (good_cnt_q + GOOD_ONE == GOOD_LOCK) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        err_d      = 1'b1;
                        state_d    = ST_HUNT;
                        bit_cnt_d  = 3'd0;
                        word_cnt_d = '0;
                        good_cnt_d = '0;
                    end
                end else if (SYNC_IN) begin
                    // Slip: this bit becomes bit 0 of a fresh verification run.
                    err_d      = 1'b1;
                    bit_cnt_d  = 3'd1;
                    word_cnt_d = '0;
                    good_cnt_d = GOOD_ONE;
                end
            end

            ST_LOCKED: begin
                if (sync_exp && !SYNC_IN) begin
                    // The word that just finished was already delivered.
                    err_d      = 1'b1;
                    state_d    = ST_HUNT;
                    bit_cnt_d  = 3'd0;
                    word_cnt_d = '0;
                    good_cnt_d = '0;
                end else if (!sync_exp && SYNC_IN) begin
                    // Slip: the partial word is abandoned, even at bit 7.
                    err_d      = 1'b1;
                    state_d    = ST_VERIFY;
                    bit_cnt_d  = 3'd1;
                    word_cnt_d = '0;
                    good_cnt_d = GOOD_ONE;
                end else if (last_bit) begin
                    deliver = 1'b1;
                end
            end

            default: begin
                state_d    = ST_HUNT;
                bit_cnt_d  = 3'd0;
                word_cnt_d = '0;
                good_cnt_d = '0;
            end
        endcase
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge fast_clk) begin
        if (!rst_n) begin
            state_q       <= ST_HUNT;
            bit_cnt_q     <= 3'd0;
            word_cnt_q    <= '0;
            good_cnt_q    <= '0;
            shift_q       <= 7'd0;
            sample_word_q <= 8'd0;
            word_valid_q  <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            good_cnt_q   <= good_cnt_d;
            shift_q      <= shift_d;
            word_valid_q <= deliver;
            sync_err_q   <= err_d;
            if (deliver) begin
                sample_word_q <= {DATA_IN, shift_q};
            end
        end
    end

`ifdef DEFRAMER_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    // Saturating count of framing errors.
    always_ff @(posedge fast_clk) begin
        if (!rst_n) begin
            err_cnt_q <= 16'h0000;
        end else if (err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'h0001;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 16'h0000;
`endif

    assign sample_word = sample_word_q;
    assign word_valid  = word_valid_q;
    assign sync_err    = sync_err_q;
    assign locked      = (state_q == ST_LOCKED);
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_ser_deframer.sv
// Bench for ser_deframer: one instance with SYNC_PERIOD=1 and one with
// SYNC_PERIOD=4, both LOCK_COUNT=4. Stimulus pushes the words it expects to be
// delivered; a negedge monitor pops and compares on every word_valid.
module tb_ser_deframer;

    // ---------------- clock / reset ----------------
    logic fast_clk = 1'b0;
    logic rst_n    = 1'b0;
    always #5 fast_clk = ~fast_clk;

    logic        u1_data = 1'b0, u1_sync = 1'b0;
    logic [7:0]  u1_word;
    logic        u1_valid, u1_locked, u1_err;
    logic [15:0] u1_errcnt;
    logic [1:0]  u1_state;

    logic        u4_data = 1'b0, u4_sync = 1'b0;
    logic [7:0]  u4_word;
    logic        u4_valid, u4_locked, u4_err;
    logic [15:0] u4_errcnt;
    logic [1:0]  u4_state;

    ser_deframer #(.SYNC_PERIOD(1), .LOCK_COUNT(4)) u1 (
        .fast_clk(fast_clk), .rst_n(rst_n), .DATA_IN(u1_data), .SYNC_IN(u1_sync),
        .sample_word(u1_word), .word_valid(u1_valid), .locked(u1_locked),
        .sync_err(u1_err), .err_count(u1_errcnt), .state_dbg_o(u1_state)
    );

    ser_deframer #(.SYNC_PERIOD(4), .LOCK_COUNT(4)) u4 (
        .fast_clk(fast_clk), .rst_n(rst_n), .DATA_IN(u4_data), .SYNC_IN(u4_sync),
        .sample_word(u4_word), .word_valid(u4_valid), .locked(u4_locked),
        .sync_err(u4_err), .err_count(u4_errcnt), .state_dbg_o(u4_state)
    );

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q1[$];
    logic [7:0] exp_q4[$];
    int n_checks = 0;
    int n_fail   = 0;
    int u1_err_seen = 0;
    int u4_err_seen = 0;
    int u1_err_exp  = 0;

    logic [7:0] tbl [16] = '{8'hA5, 8'h3C, 8'h0F, 8'h96, 8'h71, 8'h5A, 8'hC3, 8'hE1,
                             8'h18, 8'h7E, 8'hB4, 8'h2D, 8'h69, 8'hD2, 8'h47, 8'hF0};
    int widx = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_errcnt(input int n);
`ifdef DEFRAMER_ERR_CNT_EN
        return (n > 65535) ? 16'hFFFF : 16'(n);
`else
        return (n > 0) ? 16'h0000 : 16'h0000;
`endif
    endfunction

    // ---------------- monitor ----------------
    always @(negedge fast_clk) begin
        logic [7:0] e;
        if (u1_valid === 1'b1) begin
            if (exp_q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL u1_unexpected_valid: got word 0x%0h expected no word_valid at %0t", u1_word, $time);
            end else begin
                e = exp_q1.pop_front();
                chk("u1_word", 32'(u1_word), 32'(e));
            end
        end
        if (u4_valid === 1'b1) begin
            if (exp_q4.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL u4_unexpected_valid: got word 0x%0h expected no word_valid at %0t", u4_word, $time);
            end else begin
                e = exp_q4.pop_front();
                chk("u4_word", 32'(u4_word), 32'(e));
            end
        end
        if (u1_err === 1'b1) u1_err_seen++;
        if (u4_err === 1'b1) u4_err_seen++;
    end

    // ---------------- driver tasks ----------------
    // Sends nb bits of w (LSB first); sync on bit 0 if sy. dlv: word expected
    // out. chk0: after bit 0 check locked/sync_err against lk0/er0.
    task automatic send_word(input int inst, input logic [7:0] w, input logic sy,
                             input logic dlv, input int nb, input logic chk0,
                             input logic lk0, input logic er0);
        logic v, lk, er;
        if (dlv) begin
            if (inst == 1) exp_q1.push_back(w);
            else           exp_q4.push_back(w);
        end
        for (int i = 0; i < nb; i++) begin
            if (inst == 1) begin
                u1_data = w[i];
                u1_sync = (i == 0) && sy;
            end else begin
                u4_data = w[i];
                u4_sync = (i == 0) && sy;
            end
            @(posedge fast_clk);
            #1;
            v  = (inst == 1) ? u1_valid  : u4_valid;
            lk = (inst == 1) ? u1_locked : u4_locked;
            er = (inst == 1) ? u1_err    : u4_err;
            if (i == 0 && chk0) begin
                chk($sformatf("u%0d_locked_b0", inst), 32'(lk), 32'(lk0));
                chk($sformatf("u%0d_sync_err_b0", inst), 32'(er), 32'(er0));
            end
            if (i == 7) chk($sformatf("u%0d_valid_b7", inst), 32'(v), 32'(dlv));
        end
        u1_sync = 1'b0;
        u4_sync = 1'b0;
    endtask

    task automatic send_next(input logic sy, input logic dlv, input logic chk0,
                             input logic lk0, input logic er0);
        send_word(1, tbl[widx % 16], sy, dlv, 8, chk0, lk0, er0);
        widx++;
    endtask

    // Relock from HUNT (or right after a slip word): three syncs in VERIFY,
    // the fourth locks and is delivered.
    task automatic relock_tail(input int n_verify);
        for (int i = 0; i < n_verify; i++) send_next(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_next(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset with random inputs for 3 cycles.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            u1_data = 1'($urandom_range(0, 1));
            u1_sync = 1'($urandom_range(0, 1));
            u4_data = 1'($urandom_range(0, 1));
            u4_sync = 1'($urandom_range(0, 1));
            @(posedge fast_clk);
            #1;
            chk("rst_word", 32'(u1_word), 32'h0);
            chk("rst_valid", 32'(u1_valid), 32'h0);
            chk("rst_locked", 32'(u1_locked), 32'h0);
            chk("rst_sync_err", 32'(u1_err), 32'h0);
            chk("rst_err_count", 32'(u1_errcnt), 32'h0);
        end
        u1_data = 1'b0; u1_sync = 1'b0; u4_data = 1'b0; u4_sync = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge fast_clk);
        #1;
        chk("idle_locked", 32'(u1_locked), 32'h0);
        chk("idle_u4_locked", 32'(u4_locked), 32'h0);

        // Lock: A5,3C,0F in VERIFY; 96 locks (locked from t25), valid at t32.
        widx = 0;
        send_next(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);   // A5
        send_next(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // 3C
        send_next(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);   // 0F: still not locked
        send_next(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);   // 96: locked after t24
        send_next(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);   // 71
        chk("lock_no_err", 32'(u1_err_seen), 32'd0);

        // Missing sync while locked: previous word delivered, then relock.
        send_next(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send_next(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);   // sync dropped
        u1_err_exp = 1;
        relock_tail(3);
        send_next(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("miss_err_seen", 32'(u1_err_seen), 32'(u1_err_exp));
        chk("miss_err_count", 32'(u1_errcnt), 32'(exp_errcnt(u1_err_exp)));

        // Slip: word cut after 5 bits, so the next sync lands at bit_cnt 5.
        send_word(1, 8'h81, 1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b0);
        send_next(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);   // slip word starts VERIFY
        u1_err_exp = 2;
        relock_tail(2);
        send_next(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send_next(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("slip_err_seen", 32'(u1_err_seen), 32'(u1_err_exp));
        chk("slip_err_count", 32'(u1_errcnt), 32'(exp_errcnt(u1_err_exp)));

        // Three more induced errors (missing syncs), total five.
        for (int k = 0; k < 3; k++) begin
            send_next(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            send_next(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        u1_err_exp = 5;
        chk("five_err_seen", 32'(u1_err_seen), 32'(u1_err_exp));
        chk("five_err_count", 32'(u1_errcnt), 32'(exp_errcnt(u1_err_exp)));
        relock_tail(2);

        // Reset for one cycle at bit 5 of a locked word.
        for (int i = 0; i < 8; i++) begin
            u1_data = tbl[widx % 16][i];
            u1_sync = (i == 0);
            rst_n   = (i != 5);
            @(posedge fast_clk);
            #1;
            if (i == 5) begin
                chk("mid_rst_word", 32'(u1_word), 32'h0);
                chk("mid_rst_valid", 32'(u1_valid), 32'h0);
                chk("mid_rst_locked", 32'(u1_locked), 32'h0);
                chk("mid_rst_sync_err", 32'(u1_err), 32'h0);
                chk("mid_rst_err_count", 32'(u1_errcnt), 32'h0);
            end
            if (i == 7) begin
                chk("post_rst_valid", 32'(u1_valid), 32'h0);
                chk("post_rst_locked", 32'(u1_locked), 32'h0);
            end
        end
        widx++;
        u1_sync = 1'b0;
        rst_n   = 1'b1;
        relock_tail(3);
        send_next(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("final_u1_err_seen", 32'(u1_err_seen), 32'(u1_err_exp));

        // SYNC_PERIOD=4: sync every 4th word, lock on word 12, then every word.
        for (int i = 0; i < 20; i++) begin
            send_word(4, tbl[i % 16], (i % 4) == 0, i >= 12, 8,
                      (i == 11) || (i == 12), i == 12, 1'b0);
        end
        chk("u4_err_seen", 32'(u4_err_seen), 32'd0);

        repeat (3) @(posedge fast_clk);
        #1;
        chk("u1_queue_empty", 32'(exp_q1.size()), 32'd0);
        chk("u4_queue_empty", 32'(exp_q4.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog: the run is a fixed number of clocks, this only guards a hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
